// File: rtl/glyph_text_streamer_pkg.sv
// rtl/glyph_text_streamer_pkg.sv - shared constants and state encoding for the glyph text streamer
package glyph_text_streamer_pkg;

   localparam int GLYPH_W     = 8;
   localparam int GLYPH_H     = 16;
   localparam int RGB565_W    = 16;
   localparam int LCD_W       = 240;
   localparam int LCD_H       = 320;
   localparam int PIX_ENTRY_W = RGB565_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/glyph_pix_fifo.sv
// rtl/glyph_pix_fifo.sv - synchronous pixel FIFO (colour + last flag) with occupancy count
module glyph_pix_fifo
   import glyph_text_streamer_pkg::*;
#(
   parameter int WIDTH = PIX_ENTRY_W,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage needs no reset; the head is only looked at while count is non-zero
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/glyph_text_streamer.sv
// rtl/glyph_text_streamer.sv - text-mode glyph renderer to RGB565 stream; cursor option via GLYPH_TEXT_CURSOR_EN
module glyph_text_streamer
   import glyph_text_streamer_pkg::*;
#(
   parameter int TEXT_COLS  = LCD_W / GLYPH_W,
   parameter int TEXT_ROWS  = LCD_H / GLYPH_H,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [RGB565_W-1:0] fg_color,
   input  logic [RGB565_W-1:0] bg_color,
`ifdef GLYPH_TEXT_CURSOR_EN
   input  logic [ADDR_W-1:0]   cursor_col,
   input  logic [ADDR_W-1:0]   cursor_row,
   input  logic                cursor_on,
`endif
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   txt_addr,
   input  logic [7:0]          txt_data,
   output logic [6:0]          ascii_code,
   output logic [3:0]          font_row,
   output logic [2:0]          font_col,
   input  logic                font_pixel,
   output logic [RGB565_W-1:0] pix_data,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic                pix_last
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t state;
   state_t state_nx;

   logic [RGB565_W-1:0] fg_l;
   logic [RGB565_W-1:0] bg_l;

   logic [2:0]        px;
   logic [ADDR_W-1:0] char_col;
   logic [3:0]        frow;
   logic [ADDR_W-1:0] char_row;

   logic              s1_valid;
   logic              s1_last;
   logic [2:0]        s1_px;
   logic [3:0]        s1_frow;
   logic              s2_valid;
   logic              s2_last;
   logic              s2_inv;
   logic [RGB565_W-1:0] s2_colour;

   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_empty;
   logic [PIX_ENTRY_W-1:0] fifo_head;

   logic start_ok;
   logic issue;
   logic issue_last;
   logic px_wrap;
   logic col_wrap;
   logic frow_wrap;
   logic row_last;
   logic drained;

`ifdef GLYPH_TEXT_CURSOR_EN
   logic [ADDR_W-1:0] cur_col_l;
   logic [ADDR_W-1:0] cur_row_l;
   logic              cur_on_l;
   logic              s1_cur;
   logic              s2_cur;
`endif

   assign start_ok  = (state == IDLE) && start;
   assign px_wrap   = (px == 3'd7);
   assign col_wrap  = (char_col == ADDR_W'(TEXT_COLS - 1));
   assign frow_wrap = (frow == 4'd15);
   assign row_last  = (char_row == ADDR_W'(TEXT_ROWS - 1));

   // A credit is consumed for every pixel between issue and FIFO, so a push never finds the FIFO full
   assign issue      = (state == RUN) &&
                       ((int'(fifo_count) + int'(s1_valid) + int'(s2_valid)) < FIFO_DEPTH);
   assign issue_last = issue && px_wrap && col_wrap && frow_wrap && row_last;
   assign drained    = !s1_valid && !s2_valid && fifo_empty;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: start only counts in IDLE, DRAIN waits for the last handshake to leave the FIFO
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start)      state_nx = RUN;
         RUN:     if (issue_last) state_nx = DRAIN;
         DRAIN:   if (drained)    state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // Status outputs decoded from state; done is the DRAIN->IDLE cycle
   always_comb begin
      busy = (state != IDLE);
      done = (state == DRAIN) && drained;
   end

   // Latch pass configuration at start and walk the raster counters on each issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fg_l     <= '0;
         bg_l     <= '0;
         px       <= '0;
         char_col <= '0;
         frow     <= '0;
         char_row <= '0;
`ifdef GLYPH_TEXT_CURSOR_EN
         cur_col_l <= '0;
         cur_row_l <= '0;
         cur_on_l  <= 1'b0;
`endif
      end else if (start_ok) begin
         fg_l     <= fg_color;
         bg_l     <= bg_color;
         px       <= '0;
         char_col <= '0;
         frow     <= '0;
         char_row <= '0;
`ifdef GLYPH_TEXT_CURSOR_EN
         cur_col_l <= cursor_col;
         cur_row_l <= cursor_row;
         cur_on_l  <= cursor_on;
`endif
      end else if (issue) begin
         px <= px + 3'd1;
         if (px_wrap) begin
            char_col <= col_wrap ? '0 : char_col + ADDR_W'(1);
            if (col_wrap) begin
               frow <= frow + 4'd1;
               if (frow_wrap) begin
                  char_row <= row_last ? '0 : char_row + ADDR_W'(1);
               end
            end
         end
      end
   end

   // Two-stage pipeline: S1 holds the buffer lookup, S2 holds the font lookup; it never stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txt_addr <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_px    <= '0;
         s1_frow  <= '0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_inv   <= 1'b0;
`ifdef GLYPH_TEXT_CURSOR_EN
         s1_cur   <= 1'b0;
         s2_cur   <= 1'b0;
`endif
      end else begin
         s1_valid <= issue;
         if (issue) begin
            txt_addr <= ADDR_W'(char_row * TEXT_COLS) + char_col;
            s1_px    <= px;
            s1_frow  <= frow;
            s1_last  <= issue_last;
`ifdef GLYPH_TEXT_CURSOR_EN
            s1_cur   <= cur_on_l && (char_col == cur_col_l) && (char_row == cur_row_l) &&
                        (frow[3:1] == 3'b111);
`endif
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_inv  <= txt_data[7];
            s2_last <= s1_last;
`ifdef GLYPH_TEXT_CURSOR_EN
            s2_cur  <= s1_cur;
`endif
         end
      end
   end

   assign ascii_code = s1_valid ? txt_data[6:0] : 7'd0;
   assign font_row   = s1_frow;
   assign font_col   = s1_px;

   // Colour select: invert attribute flips the glyph bit; the cursor bar forces a solid colour
   always_comb begin
      s2_colour = (font_pixel ^ s2_inv) ? fg_l : bg_l;
`ifdef GLYPH_TEXT_CURSOR_EN
      if (s2_cur) s2_colour = s2_inv ? bg_l : fg_l;
`endif
   end

   glyph_pix_fifo #(
      .WIDTH (PIX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (s2_valid),
      .push_data ({s2_last, s2_colour}),
      .pop       (pix_valid && pix_ready),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign pix_valid = !fifo_empty;
   assign pix_data  = pix_valid ? fifo_head[RGB565_W-1:0] : '0;
   assign pix_last  = pix_valid && fifo_head[RGB565_W];

endmodule

// File: tb/tb_glyph_text_streamer.sv
// tb/tb_glyph_text_streamer.sv - self-checking bench for glyph_text_streamer
`timescale 1ns/1ps
module tb_glyph_text_streamer;

   localparam int COLS   = 5;
   localparam int ROWS   = 2;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;
   localparam int SCR_W  = COLS * 8;
   localparam int SCR_H  = ROWS * 16;
   localparam int NPIX   = SCR_W * SCR_H;
   localparam int BUDGET = 20000;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] exp;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [15:0]       fg_color = '0;
   logic [15:0]       bg_color = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] txt_addr;
   logic [7:0]        txt_data;
   logic [6:0]        ascii_code;
   logic [3:0]        font_row;
   logic [2:0]        font_col;
   logic              font_pixel = 1'b0;
   logic [15:0]       pix_data;
   logic              pix_valid;
   logic              pix_ready = 1'b0;
   logic              pix_last;
`ifdef GLYPH_TEXT_CURSOR_EN
   logic [ADDR_W-1:0] cursor_col = '0;
   logic [ADDR_W-1:0] cursor_row = '0;
   logic              cursor_on  = 1'b0;
`endif

   logic [7:0]  tbuf [1 << ADDR_W];
   logic [7:0]  glyph_a [16];
   logic [15:0] cap [NPIX];
   logic [15:0] ref_a [NPIX];
   vec_t        vecs [12];
   logic [15:0] fg_v = '0;
   logic [15:0] bg_v = '0;
   int          cur_col_v = 0;
   int          cur_row_v = 0;
   bit          cur_on_v = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   glyph_text_streamer #(
      .TEXT_COLS  (COLS),
      .TEXT_ROWS  (ROWS),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .fg_color   (fg_color),
      .bg_color   (bg_color),
`ifdef GLYPH_TEXT_CURSOR_EN
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .cursor_on  (cursor_on),
`endif
      .busy       (busy),
      .done       (done),
      .txt_addr   (txt_addr),
      .txt_data   (txt_data),
      .ascii_code (ascii_code),
      .font_row   (font_row),
      .font_col   (font_col),
      .font_pixel (font_pixel),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_last   (pix_last)
   );

   function automatic logic [7:0] glyph_row(input logic [6:0] a, input int r);
      logic [7:0] h;
      if (a == 7'h41) return glyph_a[r];
      if (a == 7'h20) return 8'h00;
      h = 8'(int'(a) * 29 + r * 7 + 3);
      return h ^ {h[3:0], h[7:4]};
   endfunction

   function automatic logic font_bit(input logic [6:0] a, input int r, input int c);
      logic [7:0] g;
      g = glyph_row(a, r);
      return g[7 - c];
   endfunction

   // Text buffer: address register inside the DUT supplies the read latency
   assign txt_data = tbuf[txt_addr];

   // Font ROM with one registered cycle
   always @(posedge clk) font_pixel <= font_bit(ascii_code, int'(font_row), int'(font_col));

   function automatic logic [15:0] exp_pix(input int n);
      int x, y;
      logic [7:0] code;
      x = n % SCR_W;
      y = n / SCR_W;
      code = tbuf[(y / 16) * COLS + x / 8];
      if (cur_on_v && (x / 8 == cur_col_v) && (y / 16 == cur_row_v) && (y % 16 >= 14))
         return code[7] ? bg_v : fg_v;
      return (font_bit(code[6:0], y % 16, x % 8) ^ code[7]) ? fg_v : bg_v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pix_valid"}, pix_valid, 0);
      check({tag, "_pix_last"}, pix_last, 0);
      check({tag, "_pix_data"}, pix_data, 0);
      check({tag, "_txt_addr"}, txt_addr, 0);
      check({tag, "_ascii_code"}, ascii_code, 0);
      check({tag, "_font_row"}, font_row, 0);
      check({tag, "_font_col"}, font_col, 0);
   endtask

   task automatic run_frame(input int ready_pct, input int restart_at, input int reset_at);
      int n = 0;
      int cyc = 0;
      bit after_last = 1'b0;
      bit stalled = 1'b0;
      bit restarted = 1'b0;
      logic [15:0] hold_d = '0;
      logic hold_l = 1'b0;
      fg_color = fg_v;
      bg_color = bg_v;
`ifdef GLYPH_TEXT_CURSOR_EN
      cursor_col = ADDR_W'(cur_col_v);
      cursor_row = ADDR_W'(cur_row_v);
      cursor_on  = cur_on_v;
`endif
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      fg_color = ~fg_v;
      bg_color = ~bg_v;
`ifdef GLYPH_TEXT_CURSOR_EN
      cursor_on = ~cur_on_v;
`endif
      check("busy_after_start", busy, 1);
      while (cyc < BUDGET) begin
         if (after_last) begin
            check("done_after_last", done, 1);
            @(negedge clk);
            check("done_single_pulse", done, 0);
            check("busy_after_done", busy, 0);
            return;
         end
         check("no_early_done", done, 0);
         if (stalled) begin
            check("stall_valid", pix_valid, 1);
            check("stall_data", pix_data, hold_d);
            check("stall_last", pix_last, hold_l);
         end
         start = 1'b0;
         if (n == restart_at && !restarted) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         if (n == reset_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals("midpass");
            repeat (3) begin
               @(negedge clk);
               check("no_done_in_reset", done, 0);
            end
            rst_n = 1'b1;
            return;
         end
         pix_ready = ($urandom_range(0, 99) < ready_pct);
         if (pix_valid && pix_ready) begin
            check("pix_data", pix_data, exp_pix(n));
            check("pix_last", pix_last, n == NPIX - 1);
            cap[n] = pix_data;
            n++;
            after_last = (n == NPIX);
            stalled = 1'b0;
         end else begin
            stalled = pix_valid;
            hold_d  = pix_data;
            hold_l  = pix_last;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: %0d pixels after %0d cycles, required %0d", n, cyc, NPIX);
   endtask

   initial begin
      int bad;
      glyph_a = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                  8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[0]  = '{0, 0, 16'h0000};
      vecs[1]  = '{7, 0, 16'h0000};
      vecs[2]  = '{3, 2, 16'hFFFF};
      vecs[3]  = '{4, 2, 16'h0000};
      vecs[4]  = '{0, 7, 16'hFFFF};
      vecs[5]  = '{7, 7, 16'h0000};
      vecs[6]  = '{9, 5, 16'hFFFF};
      vecs[7]  = '{10, 5, 16'h0000};
      vecs[8]  = '{19, 2, 16'h0000};
      vecs[9]  = '{16, 0, 16'hFFFF};
      vecs[10] = '{23, 15, 16'hFFFF};
      vecs[11] = '{39, 31, 16'h0000};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // Plain 'A' buffer with one inverted cell, sink always ready
      for (int i = 0; i < (1 << ADDR_W); i++) tbuf[i] = (i == 2) ? 8'hC1 : 8'h41;
      fg_v = 16'hFFFF;
      bg_v = 16'h0000;
      run_frame(100, -1, -1);
      for (int i = 0; i < 12; i++)
         check("vec_table", cap[vecs[i].y * SCR_W + vecs[i].x], vecs[i].exp);
      bad = 0;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 8; x++)
            if (cap[y * SCR_W + 16 + x] !== ~cap[y * SCR_W + x]) bad++;
      check("invert_cell_complement", bad, 0);
      ref_a = cap;

      // Same buffer, sink ready 30% of cycles
      run_frame(30, -1, -1);
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (cap[i] !== ref_a[i]) bad++;
      check("stalled_sequence_equal", bad, 0);

      // Random buffer and colours, extra start while running
      for (int i = 0; i < (1 << ADDR_W); i++) tbuf[i] = 8'($urandom);
      fg_v = 16'($urandom);
      bg_v = 16'($urandom);
      run_frame(70, 1000, -1);

      // Reset in the middle of a pass, then a fresh pass with an extra start during drain
      run_frame(60, -1, 900);
      check_reset_vals("after_reset");
      run_frame(100, NPIX - 1, -1);

`ifdef GLYPH_TEXT_CURSOR_EN
      // Cursor over a blank screen
      for (int i = 0; i < (1 << ADDR_W); i++) tbuf[i] = 8'h20;
      fg_v = 16'hF800;
      bg_v = 16'h001F;
      cur_col_v = 0;
      cur_row_v = 0;
      cur_on_v  = 1'b1;
      run_frame(100, -1, -1);
      check("cursor_y14_x0", cap[14 * SCR_W + 0], 16'hF800);
      check("cursor_y15_x7", cap[15 * SCR_W + 7], 16'hF800);
      check("cursor_y13_x0", cap[13 * SCR_W + 0], 16'h001F);
      check("cursor_y14_x8", cap[14 * SCR_W + 8], 16'h001F);
      check("cursor_y30_x0", cap[30 * SCR_W + 0], 16'h001F);

      // Cursor at a random cell over random text
      for (int i = 0; i < (1 << ADDR_W); i++) tbuf[i] = 8'($urandom);
      cur_col_v = int'($urandom_range(0, COLS - 1));
      cur_row_v = int'($urandom_range(0, ROWS - 1));
      run_frame(50, -1, -1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
